// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   Parametrised pipelined adder. The WIDTH-bit operands are split into STAGES
//   equal segments of SEG = WIDTH/STAGES bits. Stage k ripple-adds segment k
//   and registers the carry that feeds stage k+1, so the critical path is SEG
//   full-adder cells plus one register. One operation per cycle is accepted
//   under a valid/ready handshake with full backpressure. Latency is STAGES
//   cycles.
//
// Parameters:
//   WIDTH  - operand/sum width in bits (>= 2)
//   STAGES - pipeline depth and segment count; must divide WIDTH exactly
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  adder can accept operands this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry into bit 0
//   sub        in   (only with PIPELINED_ADDER_SUB_EN) 1 = a - b - ~cin
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   sum        out  a + b + cin modulo 2^WIDTH (registered)
//   cout       out  carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        out  two's-complement overflow (carry into MSB ^ carry out)
//
// Configuration macro:
//   PIPELINED_ADDER_SUB_EN - adds the sub input and subtract support.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Plain ripple-carry add of one segment.
  // Returns {carry_out, carry_into_segment_msb, segment_sum}.
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic           c;
    logic           cm;
    logic [SEG-1:0] s;
    c  = ci;
    cm = ci;
    s  = '0;
    for (int i = 0; i < SEG; i++) begin
      cm   = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, cm, s};
  endfunction

  // Per-stage registers. Each stage carries the full operand words forward;
  // only the not-yet-added upper segments are consumed downstream, so the
  // already-added low bits of r_a/r_b are trimmed away by synthesis.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  // Next-state values for each stage.
  logic             w_vin [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_b   [STAGES];
  logic [WIDTH-1:0] w_s   [STAGES];
  logic             w_co  [STAGES];
  logic             w_ovf;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_adv;

`ifdef PIPELINED_ADDER_SUB_EN
  // a - b - ~cin == a + ~b + cin; inverting b once at entry means the sub
  // flag is baked into the stored operand and travels with its operation.
  assign w_b_eff = b ^ {WIDTH{sub}};
`else
  assign w_b_eff = b;
`endif

  // The whole pipe advances whenever the output slot is empty or being popped.
  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

  always_comb begin
    logic [SEG+1:0] t;
    w_ovf = 1'b0;

    // Stage 0 input: segment 0 of the incoming operands.
    w_vin[0]          = in_valid;
    w_a[0]            = a;
    w_b[0]            = w_b_eff;
    t                 = seg_add(a[SEG-1:0], w_b_eff[SEG-1:0], cin);
    w_s[0]            = '0;
    w_s[0][SEG-1:0]   = t[SEG-1:0];
    w_co[0]           = t[SEG+1];
    if (STAGES == 1) w_ovf = t[SEG+1] ^ t[SEG];

    // Stages 1..STAGES-1: segment k plus the registered carry from stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k]              = r_vld[k-1];
      w_a[k]                = r_a[k-1];
      w_b[k]                = r_b[k-1];
      t                     = seg_add(r_a[k-1][k*SEG +: SEG],
                                      r_b[k-1][k*SEG +: SEG], r_c[k-1]);
      w_s[k]                = r_s[k-1];
      w_s[k][k*SEG +: SEG]  = t[SEG-1:0];
      w_co[k]               = t[SEG+1];
      if (k == STAGES - 1) w_ovf = t[SEG+1] ^ t[SEG];
    end
  end

  // Pipeline registers: every rank shifts together on w_adv, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vin[k];
        r_a[k]   <= w_a[k];
        r_b[k]   <= w_b[k];
        r_s[k]   <= w_s[k];
        r_c[k]   <= w_co[k];
      end
      r_ovf <= w_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Self-checking bench for pipelined_adder. Expected results come from a
// whole-word arithmetic model (a + b' + cin in WIDTH+1 bits, sign rule for
// overflow) held in an in-order queue.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  // Expected results in order: {cout, ovf, sum}.
  logic [WIDTH+1:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             ci,
                                             input logic             s);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;
    logic             ov;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci};
    ov   = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {full[WIDTH], ov, full[WIDTH-1:0]};
  endfunction

  function automatic logic rand_sub();
`ifdef PIPELINED_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
    sub      = rand_sub();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  // One operation through an empty pipe: latency and value.
  task automatic run_one(input string name, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic ci, input logic s);
    logic [WIDTH+1:0] e;
    int n;
    e        = model(x, y, ci, s);
    out_ready = 1'b1;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    tick();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < STAGES + 8) begin tick(); n++; end
    checks++; if (n !== STAGES) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, STAGES); end
    checks++; if ({cout, ovf, sum} !== e) begin errors++; $display("FAIL %s_result: got %h expected %h", name, {cout, ovf, sum}, e); end
    tick();
  endtask

  task automatic test_directed();
    run_one("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_one("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_one("ovf_neg",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SUB_EN
    run_one("sub_borrow",   32'd5, 32'd7, 1'b1, 1'b1);
    run_one("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1);
`endif
  endtask

  // 16 back-to-back transfers with out_ready held high.
  task automatic test_back_to_back();
    int first_c, last_c, seen;
    first_c = -1; last_c = -1; seen = 0;
    out_ready = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 16 + STAGES + 4; c++) begin
      if (c < 16) drive_rand(); else in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got result %h expected none", sum);
        end else begin
          logic [WIDTH+1:0] e;
          e = exp_q.pop_front();
          if ({cout, ovf, sum} !== e) begin errors++; $display("FAIL stream_data: got %h expected %h", {cout, ovf, sum}, e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      tick();
    end
    checks++; if (first_c !== STAGES) begin errors++; $display("FAIL stream_first: got %0d expected %0d", first_c, STAGES); end
    checks++; if (seen !== 16 || last_c - first_c !== 15) begin errors++; $display("FAIL stream_count: got %0d over %0d cycles expected 16 consecutive", seen, last_c - first_c + 1); end
  endtask

  // Stall the output for several cycles with input pressure, then drain.
  task automatic test_backpressure();
    int stall, pushed, popped, guard;
    stall = 0; pushed = 0; popped = 0; guard = 0;
    exp_q.delete();
    out_ready = 1'b0;
    while (stall < 5 && guard < STAGES + 20) begin
      drive_rand();
      checks++;
      if (in_ready !== (out_ready | ~out_valid)) begin errors++; $display("FAIL bp_in_ready: got %b expected %b", in_ready, out_ready | ~out_valid); end
      if (out_valid === 1'b1) begin
        stall++;
        checks++;
        if (exp_q.size() == 0 || {cout, ovf, sum} !== exp_q[0]) begin
          errors++; $display("FAIL bp_frozen: got %h expected %h", {cout, ovf, sum}, (exp_q.size() != 0) ? exp_q[0] : '0);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(a, b, cin, sub)); pushed++; end
      tick();
      guard++;
    end
    checks++; if (stall !== 5) begin errors++; $display("FAIL bp_stall: got %0d stalled cycles expected 5", stall); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && guard < STAGES + 20) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got result %h expected none", sum);
        end else begin
          logic [WIDTH+1:0] e;
          e = exp_q.pop_front();
          popped++;
          if ({cout, ovf, sum} !== e) begin errors++; $display("FAIL bp_drain: got %h expected %h", {cout, ovf, sum}, e); end
        end
      end
      tick();
      guard++;
    end
    checks++; if (popped !== pushed || pushed !== STAGES) begin errors++; $display("FAIL bp_count: got %0d delivered of %0d expected %0d", popped, pushed, STAGES); end
  endtask

  // Asynchronous reset with operations in flight.
  task automatic test_reset_midflight();
    int guard;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand(); tick(); end
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < STAGES + 8) begin tick(); guard++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_fill: got out_valid %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if ({cout, ovf, sum} !== '0) begin errors++; $display("FAIL mid_outputs: got %h expected 0", {cout, ovf, sum}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < STAGES + 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got out_valid %b expected 0 at cycle %0d", out_valid, c); end
    end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    run_one("after_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, rand_sub());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 32-bit ripple-carry adder.
- Operand width is split into STAGES equal segments. Each stage ripple-adds one segment, and the carry between segments is registered.
- Accepts one operation per cycle under a valid/ready handshake, with full backpressure.
- Drop-in arithmetic core for datapaths that need a 32-bit (or wider) add at a higher clock rate.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and number of segments; must divide WIDTH exactly, range 1..WIDTH. SEG = WIDTH/STAGES bits per segment.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  adder can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: while rst_n is low, all stage valid bits, sum, cout and ovf are 0, and in_ready is 1. Release is asynchronous-assert and synchronous-use; the first transfer can occur on the first edge after release.
- Advance enable: adv = out_ready | ~out_valid. The whole pipeline shifts one stage when adv=1 and holds every register when adv=0. in_ready = adv (combinational).
- Transfer in: a transfer occurs when in_valid & in_ready. Stage 0 captures segment 0 sum, the segment-0 carry, and the not-yet-added upper segments of a and b.
- A cycle with adv=1 and no input transfer inserts a bubble (stage 0 valid = 0).
- Stage k (1..STAGES-1) adds segment k of its carried operands plus the registered carry from stage k-1. It passes forward the completed lower sum segments and the remaining upper operand segments.
- Output: the final stage drives sum/cout/ovf registers directly; no combinational logic follows them.
- Latency: exactly STAGES cycles from the input transfer edge to out_valid=1, with no stalls.
- Throughput: one result per cycle when out_ready is held at 1.
- Per-segment add is plain ripple-carry. Critical path is SEG full-adder cells plus one register.
- STAGES=1: single registered WIDTH-bit add with latency 1.
- STAGES=WIDTH: one bit per stage.
- Backpressure: while out_valid=1 and out_ready=0, sum/cout/ovf and all internal registers stay stable and in_ready=0. Nothing is lost or duplicated.
- Output/input same cycle: out_valid=1, out_ready=1 and in_valid=1 on one edge pops the result and accepts a new input in that cycle.
- Bubbles: bubbles are not compressed. They pass through the pipe and appear as out_valid=0 cycles.
- Reset mid-operation: all in-flight operations are discarded. No partial result ever appears on the outputs.
- Wrap-around: sum is modulo 2^WIDTH. cout reports unsigned overflow; ovf reports two's-complement overflow.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, the operation is a − b − ~cin: b is inverted and the effective carry-in is cin. Callers pass cin=1 for a plain a−b.
  - cout=1 means no borrow.
  - ovf uses the same MSB-carry XOR rule.
  - sub travels with its operation; mixed add/sub streams are allowed back-to-back.
- Undefined: no sub port; add-only behaviour as above.

Test Plan:
- Carry through all segments: WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x00000000, cin=1 -> after 4 cycles sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Streaming: 16 back-to-back random transfers with out_ready=1 -> 16 consecutive out_valid cycles starting 4 cycles after the first transfer, each matching a reference model in order.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and sum/cout/ovf frozen. Raise out_ready -> all results delivered in order with none dropped.
- Reset mid-flight: 3 transfers in the pipe, pulse rst_n low asynchronously between edges -> out_valid=0 and sum=0 immediately; no stale result after release.
- Subtract (PIPELINED_ADDER_SUB_EN defined): sub=1, a=5, b=7, cin=1 -> sum=0xFFFFFFFE, cout=0. Then sub=1, a=7, b=5, cin=1 -> sum=2, cout=1. Also cover STAGES=1 and STAGES=32 builds with the same vectors.
